// File: rtl/modport_slave_pkg.sv
// modport_slave_pkg: shared FSM state type and bus width constants.
package modport_slave_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
endpackage

// File: rtl/modport_regfile.sv
// modport_regfile: register array with one synchronous write port and one combinational read port.
module modport_regfile
  import modport_slave_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter int IW = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we,
  input  logic [IW-1:0]     widx,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IW-1:0]     ridx,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [NUM_REGS];
  assign rdata = mem[ridx];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) for (int i = 0; i < NUM_REGS; i++) mem[i] <= RESET_VAL;
    else if (we) mem[widx] <= wdata;
endmodule

// File: rtl/modport_slave.sv
// modport_slave: setup/access register slave with wait states and address error reporting.
module modport_slave
  import modport_slave_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter logic [DATA_W-1:0] RESET_VAL = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sel,
  input  logic              enable,
  input  logic              ready,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              slverr
);
  localparam int IW = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
  state_t state, state_nx;
  logic valid, we, acc_write, acc_valid, decode;
  logic [IW-1:0] idx, acc_idx;
  logic [DATA_W-1:0] rd;
  assign valid = addr[1:0] == 2'b00 && {2'b00, addr[ADDR_W-1:2]} < ADDR_W'(NUM_REGS);
  assign idx = addr[IW+1:2];
  always_comb begin
    state_nx = state == IDLE  ? (sel && !enable ? SETUP : IDLE) :
               state == SETUP ? (!sel ? IDLE : enable ? ACCESS : SETUP) :
               ready ? (sel && !enable ? SETUP : IDLE) : ACCESS;
    decode   = state == SETUP && state_nx == ACCESS;
    we       = state == ACCESS && ready && sel && enable && acc_write && acc_valid;
  end
  // The address is decoded once when SETUP ends so the outputs stay frozen for all of ACCESS.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state     <= IDLE;
      rdata     <= '0;
      slverr    <= 1'b0;
      acc_write <= 1'b0;
      acc_valid <= 1'b0;
      acc_idx   <= '0;
    end else begin
      state <= state_nx;
      if (decode) begin
        acc_write <= write;
        acc_valid <= valid;
        acc_idx   <= idx;
        slverr    <= !valid;
        if (!valid) rdata <= '0;
        else if (!write) rdata <= rd;
      end else if (state_nx == IDLE) begin
        rdata  <= '0;
        slverr <= 1'b0;
      end
    end
  modport_regfile #(.NUM_REGS(NUM_REGS), .RESET_VAL(RESET_VAL), .IW(IW)) u_regfile (
    .clk    (clk),
    .reset_n(reset_n),
    .we     (we),
    .widx   (acc_idx),
    .wdata  (wdata),
    .ridx   (idx),
    .rdata  (rd)
  );
endmodule

// File: tb/tb_modport_slave.sv
// tb_modport_slave: directed transfers with hand-computed expectations for modport_slave.
module tb_modport_slave;
  logic clk = 0, reset_n = 0, sel = 0, enable = 0, ready = 0, write = 0;
  logic [31:0] addr = 0, wdata = 0, rdata;
  logic slverr;
  int total = 0, passed = 0;

  modport_slave dut (
    .clk(clk), .reset_n(reset_n), .sel(sel), .enable(enable), .ready(ready),
    .write(write), .addr(addr), .wdata(wdata), .rdata(rdata), .slverr(slverr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Full transfer: SETUP, nwait wait states, completing ACCESS; checks ACCESS outputs and IDLE return.
  task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] d, input int nwait,
                      input logic [31:0] er, input logic ee, input string tag);
    sel = 1; enable = 0; write = wr; addr = a; wdata = d; ready = 0;
    tick();
    enable = 1;
    tick();
    chk({tag, " rdata"}, rdata, er);
    chk({tag, " slverr"}, {31'b0, slverr}, {31'b0, ee});
    for (int i = 0; i < nwait; i++) begin
      tick();
      chk($sformatf("%s wait%0d rdata", tag, i), rdata, er);
      chk($sformatf("%s wait%0d slverr", tag, i), {31'b0, slverr}, {31'b0, ee});
    end
    ready = 1;
    tick();
    sel = 0; enable = 0; ready = 0; write = 0;
    chk({tag, " idle rdata"}, rdata, 32'h0);
    chk({tag, " idle slverr"}, {31'b0, slverr}, 32'h0);
  endtask

  initial begin
    tick();
    tick();
    chk("reset rdata", rdata, 32'h0);
    chk("reset slverr", {31'b0, slverr}, 32'h0);
    reset_n = 1;
    tick();
    xfer(1, 32'h04, 32'hDEAD_BEEF, 0, 32'h0, 0, "wr04");
    xfer(0, 32'h04, 32'h0, 0, 32'hDEAD_BEEF, 0, "rd04");
    xfer(0, 32'h04, 32'h0, 3, 32'hDEAD_BEEF, 0, "rd04wait");
    xfer(1, 32'h40, 32'h1234_5678, 1, 32'h0, 1, "wr40err");
    xfer(0, 32'h00, 32'h0, 0, 32'h0, 0, "rd00after40");
    xfer(0, 32'h04, 32'h0, 0, 32'hDEAD_BEEF, 0, "rd04after40");
    xfer(0, 32'h40, 32'h0, 0, 32'h0, 1, "rd40err");
    xfer(0, 32'h06, 32'h0, 0, 32'h0, 1, "rd06mis");
    xfer(1, 32'h08, 32'h0000_0011, 0, 32'h0, 0, "wr08");
    xfer(0, 32'h08, 32'h0, 0, 32'h0000_0011, 0, "rd08b2b");
    xfer(0, 32'h3C, 32'h0, 0, 32'h0, 0, "rd3Clast");
    // enable without SETUP must neither write nor disturb outputs
    sel = 1; enable = 1; write = 1; ready = 1; addr = 32'h0C; wdata = 32'hFFFF_FFFF;
    tick();
    tick();
    chk("noset rdata", rdata, 32'h0);
    chk("noset slverr", {31'b0, slverr}, 32'h0);
    sel = 0; enable = 0; write = 0; ready = 0;
    xfer(0, 32'h0C, 32'h0, 0, 32'h0, 0, "rd0Cnoset");
    // reset in the middle of a read's wait state
    sel = 1; enable = 0; write = 0; addr = 32'h04; ready = 0;
    tick();
    enable = 1;
    tick();
    chk("midrd rdata", rdata, 32'hDEAD_BEEF);
    #2 reset_n = 0;
    #1;
    chk("midrst rdata", rdata, 32'h0);
    chk("midrst slverr", {31'b0, slverr}, 32'h0);
    sel = 0; enable = 0;
    tick();
    reset_n = 1;
    tick();
    xfer(0, 32'h00, 32'h0, 0, 32'h0, 0, "rd00rst");
    xfer(0, 32'h04, 32'h0, 0, 32'h0, 0, "rd04rst");
    xfer(0, 32'h08, 32'h0, 0, 32'h0, 0, "rd08rst");
    // reset across a completing write edge aborts the write
    sel = 1; enable = 0; write = 1; addr = 32'h0C; wdata = 32'h0000_0077; ready = 0;
    tick();
    enable = 1;
    tick();
    ready = 1;
    #2 reset_n = 0;
    tick();
    sel = 0; enable = 0; write = 0; ready = 0;
    reset_n = 1;
    tick();
    xfer(0, 32'h0C, 32'h0, 0, 32'h0, 0, "rd0Cabort");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/modport_slave.md
MODPORT_SLAVE -- requirements
Module: modport_slave

Interface
REQ-001 Parameter NUM_REGS, default 16, number of 32-bit registers in the register file.
REQ-002 Parameter RESET_VAL, default 32'h0000_0000, reset contents of every register.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 sel  input  1  slave select; marks a transfer in progress.
REQ-006 enable  input  1  access phase marker; low means setup phase, high means access phase.
REQ-007 ready  input  1  master-driven access qualifier; an access phase completes only when ready is high.
REQ-008 write  input  1  1 = write transfer, 0 = read transfer.
REQ-009 addr  input  32  byte address; word index is addr[31:2].
REQ-010 wdata  input  32  write data.
REQ-011 rdata  output  32  registered read data.
REQ-012 slverr  output  1  registered transfer error flag.

Function
REQ-013 Transfer tracking SHALL use a three-state FSM: IDLE, SETUP, ACCESS.
REQ-014 IDLE->SETUP when sel=1 and enable=0; otherwise stay in IDLE.
REQ-015 SETUP->ACCESS on the next edge when sel=1 and enable=1; sel=0 SHALL return to IDLE; sel=1 with enable=0 SHALL stay in SETUP and re-decode.
REQ-016 ACCESS with ready=0 SHALL hold state, rdata, slverr and registers unchanged (wait states).
REQ-017 ACCESS with ready=1 SHALL complete the transfer; next state is SETUP if sel=1 and enable=0, otherwise IDLE.
REQ-018 An address is valid when addr[1:0]=0 and addr[31:2] < NUM_REGS; any other address is invalid.
REQ-019 At the edge ending SETUP, a valid read SHALL load rdata with reg[addr[31:2]] and clear slverr.
REQ-020 At the edge ending SETUP, an invalid address (read or write) SHALL set slverr=1 and load rdata with 0.
REQ-021 At the edge ending SETUP, a valid write SHALL clear slverr and leave rdata unchanged.
REQ-022 rdata and slverr SHALL remain stable throughout the entire ACCESS phase, including all wait states.
REQ-023 A valid write SHALL update reg[index] with wdata at the edge where ACCESS completes (sel=1, enable=1, ready=1); there is no other write path.
REQ-024 An invalid-address write SHALL NOT modify any register.
REQ-025 enable=1 without a preceding SETUP cycle SHALL be ignored: no write and no output change.
REQ-026 After a completed write, a read of the same address in the next transfer SHALL return the new data (no read-after-write hazard).
REQ-027 Transfer latency SHALL be two cycles minimum (one SETUP and one ACCESS), plus one cycle per ready=0 wait state.
REQ-028 rdata and slverr SHALL return to 0 on the edge entering IDLE.

Reset
REQ-029 reset_n=0 SHALL immediately force the FSM to IDLE, rdata=0, slverr=0, and every register to RESET_VAL.
REQ-030 Reset asserted mid-transfer SHALL abort the transfer with no register write.
REQ-031 After reset_n deasserts, the first transfer SHALL begin with a SETUP phase.

Structure
REQ-032 A shared package SHALL hold the FSM state enum (IDLE, SETUP, ACCESS), the data width constant (32) and the address width constant (32).
REQ-033 One sub-module, modport_regfile, SHALL hold the register array with one write port and one read port; the FSM and address decode SHALL stay in the top-level module.

Verification
REQ-034 Reset: drive reset_n=0 mid-access -> rdata=0, slverr=0, FSM in IDLE; reading addr 0x0 then returns 0x0000_0000.
REQ-035 Write/read: write 0xDEAD_BEEF to 0x04, then read 0x04 -> rdata=0xDEAD_BEEF, slverr=0.
REQ-036 Wait states: read 0x04 with ready low for 3 cycles -> rdata stays stable for all 4 ACCESS cycles and the transfer completes on the 4th.
REQ-037 Error, out of range: write 0x1234_5678 to 0x40 (NUM_REGS=16) -> slverr=1 in ACCESS, all registers unchanged; read 0x40 -> slverr=1, rdata=0.
REQ-038 Error, misaligned: read 0x06 -> slverr=1, rdata=0.
REQ-039 Back-to-back: write 0x0000_0011 to 0x08 followed directly by SETUP of a read of 0x08 -> rdata=0x0000_0011.
